// File: rtl/uart_baud_gen_if.sv
// Configuration and strobe signals between the UART engines and the baud-rate generator.
// The generator takes the slave side; the UART engines take the master side.
interface uart_baud_gen_if #(
   parameter int DIV_WIDTH  = 16,
   parameter int FRAC_WIDTH = 4
);
   logic [DIV_WIDTH-1:0]  i_divisor;
   logic [FRAC_WIDTH-1:0] i_frac;
   logic                  i_cfg_load;
   logic                  o_cfg_pending;
   logic                  o_cfg_error;
   logic                  i_rx_strb_en;
   logic                  o_rx_strb;
   logic                  i_tx_strb_en;
   logic                  o_tx_strb;

   modport master (
      output i_divisor, i_frac, i_cfg_load, i_rx_strb_en, i_tx_strb_en,
      input  o_cfg_pending, o_cfg_error, o_rx_strb, o_tx_strb
   );

   modport slave (
      input  i_divisor, i_frac, i_cfg_load, i_rx_strb_en, i_tx_strb_en,
      output o_cfg_pending, o_cfg_error, o_rx_strb, o_tx_strb
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Baud-rate strobe generator: mid-bit RX sample strobes and full-period TX strobes,
// with an integer-plus-fraction bit period so long runs do not drift.
module uart_baud_gen #(
   parameter int DIV_WIDTH  = 16,
   parameter int FRAC_WIDTH = 4,
   parameter int RESET_DIV  = 868
) (
   input logic            clk,
   input logic            rst,
   uart_baud_gen_if.slave bus
);
   localparam int CNT_WIDTH = DIV_WIDTH + 1;
   localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(4);
   localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [1:0] {RX_IDLE, RX_HALF, RX_RUN} rx_state_t;
   typedef enum logic {TX_IDLE, TX_RUN} tx_state_t;

   logic [DIV_WIDTH-1:0]  div_q;
   logic [FRAC_WIDTH-1:0] frac_q;
   logic                  cfg_pending;
   logic                  cfg_error;
   logic                  engines_idle;
   logic                  apply_cfg;
   logic [CNT_WIDTH-1:0]  base_period;
   logic [CNT_WIDTH-1:0]  half_period;

   rx_state_t             rx_state;
   logic [CNT_WIDTH-1:0]  rx_cnt;
   logic [FRAC_WIDTH-1:0] rx_acc;
   logic                  rx_strb;
   logic [FRAC_WIDTH:0]   rx_sum;
   logic [CNT_WIDTH-1:0]  rx_period;

   tx_state_t             tx_state;
   logic [CNT_WIDTH-1:0]  tx_cnt;
   logic [FRAC_WIDTH-1:0] tx_acc;
   logic                  tx_strb;
   logic [FRAC_WIDTH:0]   tx_sum;
   logic [CNT_WIDTH-1:0]  tx_period;

   assign engines_idle = !bus.i_rx_strb_en && !bus.i_tx_strb_en;
   assign apply_cfg    = engines_idle && (bus.i_cfg_load || cfg_pending);

   // One extra counter bit keeps D+1 representable at the maximum divisor.
   assign base_period = {1'b0, div_q};
   assign half_period = {2'b00, div_q[DIV_WIDTH-1:1]};

   assign rx_sum    = {1'b0, rx_acc} + {1'b0, frac_q};
   assign rx_period = base_period + {{DIV_WIDTH{1'b0}}, rx_sum[FRAC_WIDTH]};
   assign tx_sum    = {1'b0, tx_acc} + {1'b0, frac_q};
   assign tx_period = base_period + {{DIV_WIDTH{1'b0}}, tx_sum[FRAC_WIDTH]};

   // The period may only change while both engines are stopped, so a running
   // engine never sees its divisor move underneath it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q       <= RST_DIV;
         frac_q      <= '0;
         cfg_pending <= 1'b0;
         cfg_error   <= 1'b0;
      end else if (apply_cfg) begin
         cfg_pending <= 1'b0;
         frac_q      <= bus.i_frac;
         if (bus.i_divisor < MIN_DIV) begin
            div_q     <= MIN_DIV;
            cfg_error <= 1'b1;
         end else begin
            div_q     <= bus.i_divisor;
            cfg_error <= 1'b0;
         end
      end else if (bus.i_cfg_load) begin
         cfg_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_acc   <= '0;
         rx_strb  <= 1'b0;
      end else begin
         rx_strb <= 1'b0;
         if (!bus.i_rx_strb_en) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_acc   <= '0;
         end else begin
            case (rx_state)
               RX_IDLE: begin
                  rx_state <= RX_HALF;
                  rx_cnt   <= half_period;
               end
               RX_HALF, RX_RUN: begin
                  if (rx_cnt == CNT_ONE) begin
                     rx_strb  <= 1'b1;
                     rx_state <= RX_RUN;
                     rx_acc   <= rx_sum[FRAC_WIDTH-1:0];
                     rx_cnt   <= rx_period;
                  end else begin
                     rx_cnt <= rx_cnt - CNT_ONE;
                  end
               end
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_acc   <= '0;
         tx_strb  <= 1'b0;
      end else begin
         tx_strb <= 1'b0;
         if (!bus.i_tx_strb_en) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_acc   <= '0;
         end else begin
            case (tx_state)
               TX_IDLE: begin
                  tx_state <= TX_RUN;
                  tx_cnt   <= base_period;
               end
               TX_RUN: begin
                  if (tx_cnt == CNT_ONE) begin
                     tx_strb <= 1'b1;
                     tx_acc  <= tx_sum[FRAC_WIDTH-1:0];
                     tx_cnt  <= tx_period;
                  end else begin
                     tx_cnt <= tx_cnt - CNT_ONE;
                  end
               end
               default: tx_state <= TX_IDLE;
            endcase
         end
      end
   end

   assign bus.o_cfg_pending = cfg_pending;
   assign bus.o_cfg_error   = cfg_error;
   assign bus.o_rx_strb     = rx_strb;
   assign bus.o_tx_strb     = tx_strb;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: strobe edge numbers are compared against times computed
// from the bit-period rules, and the configuration flags are tracked every cycle.
module tb_uart_baud_gen;
   localparam int DivWidth  = 16;
   localparam int FracWidth = 4;
   localparam int ResetDiv  = 868;
   localparam int FracMod   = 1 << FracWidth;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int compared = 0;
   int mismatched = 0;
   int rxSeen[$];
   int txSeen[$];
   int expRx[$];
   int expTx[$];
   int mDiv, mFrac, lastBase;
   bit mErr, mPend;
   int total, rs, rp, ts, tp, la, ldDiv, ldFrac;

   uart_baud_gen_if #(.DIV_WIDTH(DivWidth), .FRAC_WIDTH(FracWidth)) bus ();

   uart_baud_gen #(
      .DIV_WIDTH(DivWidth),
      .FRAC_WIDTH(FracWidth),
      .RESET_DIV(ResetDiv)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobes are recorded by the number of the edge that launched them.
   always @(negedge clk) begin
      if (bus.o_rx_strb) rxSeen.push_back(cyc);
      if (bus.o_tx_strb) txSeen.push_back(cyc);
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int seenAt(input bit isRx, input int k);
      if (isRx) return (k < rxSeen.size()) ? rxSeen[k] : -1;
      return (k < txSeen.size()) ? txSeen[k] : -1;
   endfunction

   // Strobe times from the bit-period rules: first strobe after D/2 (RX) or D (TX),
   // then every D clocks plus one whenever the fractional sum wraps.
   task automatic buildExpected(input bit isRx, input int d, input int f, input int t0,
                                input int tStop);
      int t;
      int acc;
      t = isRx ? t0 + d / 2 : t0 + d;
      acc = 0;
      while (t < tStop) begin
         if (isRx) expRx.push_back(t);
         else expTx.push_back(t);
         acc = acc + f;
         t = t + d + acc / FracMod;
         acc = acc % FracMod;
      end
   endtask

   task automatic compareStrobes(input bit isRx);
      int n;
      n = isRx ? expRx.size() : expTx.size();
      checkOutput(isRx ? "rxCount" : "txCount",
                  isRx ? rxSeen.size() : txSeen.size(), n);
      for (int k = 0; k < n; k++)
         checkOutput(isRx ? "rxTime" : "txTime", seenAt(isRx, k),
                     isRx ? expRx[k] : expTx[k]);
   endtask

   // Runs a window of 'total' edges; an engine is enabled at edges start..stop-1
   // (start 0 keeps it off) and i_cfg_load pulses at edge loadAt (0 for none).
   task automatic applyStimulus(input int rxStart, input int rxStop, input int txStart,
                                input int txStop, input int tot, input int loadAt,
                                input int loadDiv, input int loadFrac);
      int base, rxD, rxF, txD, txF;
      bit rxE, txE, ld;
      base = cyc;
      lastBase = base;
      rxSeen.delete(); txSeen.delete(); expRx.delete(); expTx.delete();
      rxD = mDiv; rxF = mFrac; txD = mDiv; txF = mFrac;
      bus.i_divisor = DivWidth'(loadDiv);
      bus.i_frac    = FracWidth'(loadFrac);
      for (int i = 1; i <= tot; i++) begin
         rxE = (rxStart != 0) && (i >= rxStart) && (i < rxStop);
         txE = (txStart != 0) && (i >= txStart) && (i < txStop);
         ld  = (i == loadAt);
         bus.i_rx_strb_en = rxE;
         bus.i_tx_strb_en = txE;
         bus.i_cfg_load   = ld;
         if (i == rxStart) begin rxD = mDiv; rxF = mFrac; end
         if (i == txStart) begin txD = mDiv; txF = mFrac; end
         if ((ld || mPend) && !rxE && !txE) begin
            mDiv  = (loadDiv < 4) ? 4 : loadDiv;
            mFrac = loadFrac;
            mErr  = (loadDiv < 4);
            mPend = 1'b0;
         end else if (ld) begin
            mPend = 1'b1;
         end
         @(posedge clk); #1;
         checkOutput("cfgPending", int'(bus.o_cfg_pending), int'(mPend));
         checkOutput("cfgError", int'(bus.o_cfg_error), int'(mErr));
      end
      bus.i_rx_strb_en = 1'b0;
      bus.i_tx_strb_en = 1'b0;
      bus.i_cfg_load   = 1'b0;
      @(posedge clk); #1;
      if (rxStart != 0) buildExpected(1'b1, rxD, rxF, base + rxStart, base + rxStop);
      if (txStart != 0) buildExpected(1'b0, txD, txF, base + txStart, base + txStop);
      compareStrobes(1'b1);
      compareStrobes(1'b0);
   endtask

   initial begin
      bus.i_divisor = '0;
      bus.i_frac = '0;
      bus.i_cfg_load = 1'b0;
      bus.i_rx_strb_en = 1'b0;
      bus.i_tx_strb_en = 1'b0;
      mDiv = ResetDiv; mFrac = 0; mErr = 1'b0; mPend = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstRxStrb", int'(bus.o_rx_strb), 0);
      checkOutput("rstTxStrb", int'(bus.o_tx_strb), 0);
      checkOutput("rstPending", int'(bus.o_cfg_pending), 0);
      checkOutput("rstError", int'(bus.o_cfg_error), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] reset-default divisor");
      applyStimulus(1, 1310, 0, 0, 1312, 0, 0, 0);
      checkOutput("rxFirstDefault", seenAt(1'b1, 0) - (lastBase + 1), 434);
      checkOutput("rxSecondDefault", seenAt(1'b1, 1) - (lastBase + 1), 1302);

      $display("[TB] fractional spacing D=10 F=8");
      applyStimulus(0, 0, 0, 0, 2, 1, 10, 8);
      applyStimulus(1, 60, 1, 60, 62, 0, 10, 8);
      checkOutput("rxFirstFrac", seenAt(1'b1, 0) - (lastBase + 1), 5);
      checkOutput("txFirstFrac", seenAt(1'b0, 0) - (lastBase + 1), 10);
      checkOutput("rxSpacing1", seenAt(1'b1, 2) - seenAt(1'b1, 1), 11);
      checkOutput("txSpacing1", seenAt(1'b0, 2) - seenAt(1'b0, 1), 11);

      $display("[TB] enable drop and restart");
      applyStimulus(1, 17, 0, 0, 25, 0, 10, 8);
      checkOutput("rxAfterDrop", rxSeen.size(), 2);
      applyStimulus(1, 40, 0, 0, 42, 0, 10, 8);
      checkOutput("rxRestartFirst", seenAt(1'b1, 0) - (lastBase + 1), 5);
      checkOutput("rxRestartSpacing", seenAt(1'b1, 1) - seenAt(1'b1, 0), 10);

      $display("[TB] divisor clamp");
      applyStimulus(0, 0, 0, 0, 2, 1, 2, 0);
      checkOutput("errAfterClamp", int'(bus.o_cfg_error), 1);
      applyStimulus(0, 0, 1, 30, 32, 0, 2, 0);
      checkOutput("txClampPeriod", seenAt(1'b0, 1) - seenAt(1'b0, 0), 4);
      applyStimulus(0, 0, 0, 0, 2, 1, 6, 0);
      checkOutput("errCleared", int'(bus.o_cfg_error), 0);
      applyStimulus(0, 0, 1, 30, 32, 0, 6, 0);
      checkOutput("txPeriodSix", seenAt(1'b0, 1) - seenAt(1'b0, 0), 6);

      $display("[TB] deferred load");
      applyStimulus(0, 0, 0, 0, 2, 1, 10, 0);
      applyStimulus(1, 60, 0, 0, 62, 20, 20, 0);
      checkOutput("deferredSpacing", seenAt(1'b1, 3) - seenAt(1'b1, 2), 10);
      applyStimulus(1, 40, 0, 0, 42, 0, 20, 0);
      checkOutput("deferredHalf", seenAt(1'b1, 0) - (lastBase + 1), 10);
      applyStimulus(1, 30, 0, 0, 32, 1, 12, 0);

      $display("[TB] randomized windows");
      for (int trial = 0; trial < 25; trial++) begin
         total  = $urandom_range(160, 60);
         rs     = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(20, 1);
         rp     = $urandom_range(total, rs + 1);
         ts     = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(20, 1);
         tp     = $urandom_range(total, ts + 1);
         la     = ($urandom_range(1, 0) == 1) ? $urandom_range(total, 1) : 0;
         ldDiv  = $urandom_range(40, 0);
         ldFrac = $urandom_range(FracMod - 1, 0);
         applyStimulus(rs, rp, ts, tp, total, la, ldDiv, ldFrac);
      end

      $display("[TB] reset mid-run");
      applyStimulus(0, 0, 0, 0, 2, 1, 3, 0);
      rxSeen.delete(); txSeen.delete();
      bus.i_divisor = DivWidth'(50);
      bus.i_rx_strb_en = 1'b1;
      bus.i_tx_strb_en = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      bus.i_cfg_load = 1'b1;
      @(posedge clk); #1;
      bus.i_cfg_load = 1'b0;
      checkOutput("pendBeforeReset", int'(bus.o_cfg_pending), 1);
      checkOutput("errBeforeReset", int'(bus.o_cfg_error), 1);
      checkOutput("runBeforeReset", int'(rxSeen.size() > 0), 1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checkOutput("rxInReset", int'(bus.o_rx_strb), 0);
      checkOutput("txInReset", int'(bus.o_tx_strb), 0);
      checkOutput("pendInReset", int'(bus.o_cfg_pending), 0);
      checkOutput("errInReset", int'(bus.o_cfg_error), 0);
      bus.i_rx_strb_en = 1'b0;
      bus.i_tx_strb_en = 1'b0;
      rxSeen.delete(); txSeen.delete();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rxStrobesInReset", rxSeen.size(), 0);
      checkOutput("txStrobesInReset", txSeen.size(), 0);
      rst = 1'b0;
      mDiv = ResetDiv; mFrac = 0; mErr = 1'b0; mPend = 1'b0;
      applyStimulus(1, 440, 1, 870, 872, 0, 0, 0);
      checkOutput("rxFirstAfterReset", seenAt(1'b1, 0) - (lastBase + 1), 434);
      checkOutput("txFirstAfterReset", seenAt(1'b0, 0) - (lastBase + 1), 868);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
